// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM: port A writes, port B reads.
// A 2-entry skid buffer absorbs the 1-cycle RAM read latency and keeps pops first-word-fall-through.
module dpram_fifo_ctrl #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          ena,
  output logic          wea,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] data_i_a,
  output logic          enb,
  output logic          web,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] data_o_b
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          ram_cnt;
  logic [1:0][DW-1:0]   skid;
  logic                 sk_head;
  logic [1:0]           sk_cnt;
  logic                 inflight;
  logic                 run, push, pop, rd;
  logic [2:0]           slots_free;

  // Nothing is issued to the RAM while reset or flush is being applied.
  assign run        = rst_n & ~clr;
  assign in_ready   = (ram_cnt != DEPTH);
  assign push       = run & in_valid & in_ready;
  assign out_valid  = (sk_cnt != 2'd0);
  assign pop        = out_valid & out_ready;
  assign slots_free = 3'd2 - {1'b0, sk_cnt} - {2'b0, inflight} + {2'b0, pop};
  assign rd         = run & (ram_cnt != '0) & (slots_free != 3'd0);

  assign ena      = push;
  assign wea      = push;
  assign addra    = wr_ptr;
  assign data_i_a = push ? in_data : '0;
  assign enb      = rd;
  assign web      = 1'b0;
  assign addrb    = rd_ptr;
  assign out_data = out_valid ? skid[sk_head] : '0;
  assign level    = ram_cnt + {{(AW-1){1'b0}}, sk_cnt} + {{AW{1'b0}}, inflight};

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      sk_head  <= 1'b0;
      sk_cnt   <= 2'd0;
      inflight <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rd)   rd_ptr <= rd_ptr + 1'b1;
      case ({push, rd})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      inflight <= rd;
      // Returning word lands behind the current occupants; slot count is 0 or 1 here.
      if (inflight) skid[sk_head ^ sk_cnt[0]] <= data_o_b;
      if (pop) sk_head <= ~sk_head;
      sk_cnt <= 2'(sk_cnt + {1'b0, inflight} - {1'b0, pop});
    end
  end
endmodule
